// File: rtl/reg_file_scoreboard_if.sv
// Decode / write-back bus of the register file scoreboard.
// master = decode and write-back stages, slave = register file.
`ifndef WORD
`define WORD 32
`endif

interface reg_file_scoreboard_if #(
    parameter int unsigned WORD = `WORD
);
    // Decode-stage operand reads
    logic [4:0]      rd_addr1;
    logic [4:0]      rd_addr2;
    logic [WORD-1:0] rd_data1;
    logic [WORD-1:0] rd_data2;

    // Decode-stage issue request and its answer
    logic            issue_valid;
    logic            issue_use1;
    logic            issue_use2;
    logic            issue_writes;
    logic [4:0]      issue_dst;
    logic            stall;

    // Write-back commit port
    logic            wb_reg_write;
    logic [4:0]      wb_addr;
    logic [WORD-1:0] wb_data;

    // Status
    logic            pending_any;
    logic            wb_underflow;

    modport master (
        output rd_addr1, rd_addr2,
        output issue_valid, issue_use1, issue_use2, issue_writes, issue_dst,
        output wb_reg_write, wb_addr, wb_data,
        input  rd_data1, rd_data2, stall, pending_any, wb_underflow
    );

    modport slave (
        input  rd_addr1, rd_addr2,
        input  issue_valid, issue_use1, issue_use2, issue_writes, issue_dst,
        input  wb_reg_write, wb_addr, wb_data,
        output rd_data1, rd_data2, stall, pending_any, wb_underflow
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write counters.
// Reads are combinational with write-through bypass. Issue is stalled on
// outstanding source writes or on a saturated destination counter.
// The top register (X31 by default) reads as zero and ignores writes.
`ifndef WORD
`define WORD 32
`endif

module reg_file_scoreboard #(
    parameter int unsigned WORD = `WORD,
    parameter int unsigned NREG = 32
) (
    input logic                  id_clk,
    input logic                  id_rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int unsigned   AW       = 5;
    localparam int unsigned   CW       = 2;
    localparam logic [AW-1:0] ZERO_REG = AW'(NREG - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(3);

    // Architectural state
    logic [WORD-1:0] regs_q [NREG];
    logic [WORD-1:0] regs_d [NREG];
    logic [CW-1:0]   cnt_q  [NREG];
    logic [CW-1:0]   cnt_d  [NREG];
    logic            underflow_q;
    logic            underflow_d;
    logic            pending_any_q;
    logic            pending_any_d;

    // Combinational decode of the current cycle
    logic            wb_commit_c;
    logic            hit1_c;
    logic            hit2_c;
    logic            dst_hit_c;
    logic            src_haz1_c;
    logic            src_haz2_c;
    logic            dst_haz_c;
    logic            stall_c;
    logic            accept_c;
    logic            alloc_c;
    logic [NREG-1:0] inc_c;
    logic [NREG-1:0] dec_c;
    logic [WORD-1:0] rd1_c;
    logic [WORD-1:0] rd2_c;

    // True for an address that maps onto a real, writable register
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREG) && (a != ZERO_REG);
    endfunction

    // Effective count nonzero: a same-cycle write-back retires one write
    function automatic logic busy(input logic [CW-1:0] cnt, input logic hit);
        return hit ? (cnt > CW'(1)) : (cnt != CW'(0));
    endfunction

    // Write-back commit and its address matches against decode
    always_comb begin
        wb_commit_c = bus.wb_reg_write && addr_ok(bus.wb_addr);
        hit1_c      = wb_commit_c && (bus.wb_addr == bus.rd_addr1);
        hit2_c      = wb_commit_c && (bus.wb_addr == bus.rd_addr2);
        dst_hit_c   = wb_commit_c && (bus.wb_addr == bus.issue_dst);
    end

    // Operand reads with write-through bypass
    always_comb begin
        rd1_c = '0;
        rd2_c = '0;
        if (addr_ok(bus.rd_addr1)) begin
            rd1_c = hit1_c ? bus.wb_data : regs_q[bus.rd_addr1];
        end
        if (addr_ok(bus.rd_addr2)) begin
            rd2_c = hit2_c ? bus.wb_data : regs_q[bus.rd_addr2];
        end
    end

    // Hazard detection and issue acceptance
    always_comb begin
        src_haz1_c = bus.issue_use1 && addr_ok(bus.rd_addr1)
                     && busy(cnt_q[bus.rd_addr1], hit1_c);
        src_haz2_c = bus.issue_use2 && addr_ok(bus.rd_addr2)
                     && busy(cnt_q[bus.rd_addr2], hit2_c);
        // A write-back in the same cycle frees a slot, so a full counter
        // only blocks when nothing retires on that register.
        dst_haz_c  = bus.issue_writes && addr_ok(bus.issue_dst)
                     && (cnt_q[bus.issue_dst] == CNT_MAX) && !dst_hit_c;
        stall_c    = bus.issue_valid && (src_haz1_c || src_haz2_c || dst_haz_c);
        accept_c   = bus.issue_valid && !stall_c;
        alloc_c    = accept_c && bus.issue_writes && addr_ok(bus.issue_dst);
    end

    // Per-register increment / decrement requests
    always_comb begin
        inc_c = '0;
        dec_c = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            inc_c[i] = alloc_c && (bus.issue_dst == AW'(i));
            dec_c[i] = wb_commit_c && (bus.wb_addr == AW'(i));
        end
    end

    // Next state of the array, counters and status flags
    always_comb begin
        regs_d        = regs_q;
        cnt_d         = cnt_q;
        underflow_d   = underflow_q;
        pending_any_d = 1'b0;
        if (id_rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_d[i] = '0;
                cnt_d[i]  = '0;
            end
            underflow_d = 1'b0;
        end else begin
            if (wb_commit_c) begin
                regs_d[bus.wb_addr] = bus.wb_data;
            end
            for (int i = 0; i < int'(NREG); i++) begin
                unique case ({inc_c[i], dec_c[i]})
                    2'b10: cnt_d[i] = cnt_q[i] + CW'(1);
                    2'b01: begin
                        if (cnt_q[i] != CW'(0)) begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                    2'b11: begin
                        // Allocation and retirement cancel; a retirement
                        // with nothing outstanding is still an underflow.
                        if (cnt_q[i] == CW'(0)) begin
                            underflow_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < int'(NREG); i++) begin
            pending_any_d = pending_any_d | (cnt_d[i] != CW'(0));
        end
    end

    // State registers with synchronous reset folded into the next-state logic
    always_ff @(posedge id_clk) begin
        regs_q        <= regs_d;
        cnt_q         <= cnt_d;
        underflow_q   <= underflow_d;
        pending_any_q <= pending_any_d;
    end

    assign bus.rd_data1     = rd1_c;
    assign bus.rd_data2     = rd2_c;
    assign bus.stall        = stall_c;
    assign bus.pending_any  = pending_any_q;
    assign bus.wb_underflow = underflow_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard.
`timescale 1ns/1ps

module tb_reg_file_scoreboard;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    reg_file_scoreboard_if #(.WORD(32)) bus ();

    reg_file_scoreboard #(.WORD(32), .NREG(32)) dut (
        .id_clk (clk),
        .id_rst (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all inputs inactive
    task automatic idle();
        bus.rd_addr1     = 5'd0;
        bus.rd_addr2     = 5'd0;
        bus.issue_valid  = 1'b0;
        bus.issue_use1   = 1'b0;
        bus.issue_use2   = 1'b0;
        bus.issue_writes = 1'b0;
        bus.issue_dst    = 5'd0;
        bus.wb_reg_write = 1'b0;
        bus.wb_addr      = 5'd0;
        bus.wb_data      = 32'd0;
    endtask

    // Advance one clock; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #2;
    endtask

    task automatic issue_dst(input logic [4:0] d);
        bus.issue_valid  = 1'b1;
        bus.issue_writes = 1'b1;
        bus.issue_dst    = d;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.wb_reg_write = 1'b1;
        bus.wb_addr      = a;
        bus.wb_data      = d;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd31;
        settle();
        n_vec++; if (bus.rd_data1 !== 32'd0) begin $display("FAIL reset_rd1: got %h want %h", bus.rd_data1, 32'd0); n_err++; end
        n_vec++; if (bus.rd_data2 !== 32'd0) begin $display("FAIL reset_rd2: got %h want %h", bus.rd_data2, 32'd0); n_err++; end
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", bus.stall); n_err++; end
        n_vec++; if (bus.pending_any !== 1'b0) begin $display("FAIL reset_pending: got %b want 0", bus.pending_any); n_err++; end
        n_vec++; if (bus.wb_underflow !== 1'b0) begin $display("FAIL reset_underflow: got %b want 0", bus.wb_underflow); n_err++; end
        tick();
    endtask

    task automatic test_raw_hazard();
        idle();
        issue_dst(5'd3);
        settle();
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL raw_issue_stall: got %b want 0", bus.stall); n_err++; end
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_use1  = 1'b1;
        bus.rd_addr1    = 5'd3;
        settle();
        n_vec++; if (bus.pending_any !== 1'b1) begin $display("FAIL raw_pending: got %b want 1", bus.pending_any); n_err++; end
        n_vec++; if (bus.stall !== 1'b1) begin $display("FAIL raw_stall: got %b want 1", bus.stall); n_err++; end
        tick();
        wb(5'd3, 32'h0000_1234);
        settle();
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL raw_bypass_stall: got %b want 0", bus.stall); n_err++; end
        n_vec++; if (bus.rd_data1 !== 32'h0000_1234) begin $display("FAIL raw_bypass_data: got %h want %h", bus.rd_data1, 32'h0000_1234); n_err++; end
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_use2  = 1'b1;
        bus.rd_addr1    = 5'd3;
        bus.rd_addr2    = 5'd3;
        settle();
        n_vec++; if (bus.pending_any !== 1'b0) begin $display("FAIL raw_pending_clear: got %b want 0", bus.pending_any); n_err++; end
        n_vec++; if (bus.rd_data2 !== 32'h0000_1234) begin $display("FAIL raw_array_data: got %h want %h", bus.rd_data2, 32'h0000_1234); n_err++; end
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL raw_no_stall: got %b want 0", bus.stall); n_err++; end
        tick();
    endtask

    task automatic test_dst_saturate();
        idle();
        for (int k = 0; k < 3; k++) begin
            issue_dst(5'd7);
            settle();
            n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL sat_issue%0d: got %b want 0", k, bus.stall); n_err++; end
            tick();
        end
        issue_dst(5'd7);
        settle();
        n_vec++; if (bus.stall !== 1'b1) begin $display("FAIL sat_full_stall: got %b want 1", bus.stall); n_err++; end
        wb(5'd7, 32'h0000_0077);
        settle();
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL sat_wb_accept: got %b want 0", bus.stall); n_err++; end
        tick();
        idle();
        issue_dst(5'd7);
        settle();
        n_vec++; if (bus.stall !== 1'b1) begin $display("FAIL sat_still_full: got %b want 1", bus.stall); n_err++; end
        idle();
        for (int k = 0; k < 3; k++) begin
            wb(5'd7, 32'h0000_0070 + 32'(k));
            tick();
            idle();
            settle();
            n_vec++; if (bus.pending_any !== (k < 2)) begin $display("FAIL sat_drain%0d: got %b want %b", k, bus.pending_any, (k < 2)); n_err++; end
        end
        bus.rd_addr1 = 5'd7;
        settle();
        n_vec++; if (bus.rd_data1 !== 32'h0000_0072) begin $display("FAIL sat_last_data: got %h want %h", bus.rd_data1, 32'h0000_0072); n_err++; end
        n_vec++; if (bus.wb_underflow !== 1'b0) begin $display("FAIL sat_underflow: got %b want 0", bus.wb_underflow); n_err++; end
        tick();
    endtask

    task automatic test_zero_reg();
        idle();
        wb(5'd31, 32'h0000_FFFF);
        bus.rd_addr1 = 5'd31;
        settle();
        n_vec++; if (bus.rd_data1 !== 32'd0) begin $display("FAIL zero_bypass: got %h want %h", bus.rd_data1, 32'd0); n_err++; end
        tick();
        idle();
        bus.rd_addr2 = 5'd31;
        issue_dst(5'd31);
        bus.issue_use2 = 1'b1;
        settle();
        n_vec++; if (bus.rd_data2 !== 32'd0) begin $display("FAIL zero_read: got %h want %h", bus.rd_data2, 32'd0); n_err++; end
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL zero_stall: got %b want 0", bus.stall); n_err++; end
        n_vec++; if (bus.wb_underflow !== 1'b0) begin $display("FAIL zero_underflow: got %b want 0", bus.wb_underflow); n_err++; end
        tick();
        idle();
        settle();
        n_vec++; if (bus.pending_any !== 1'b0) begin $display("FAIL zero_pending: got %b want 0", bus.pending_any); n_err++; end
        tick();
    endtask

    task automatic test_underflow();
        idle();
        wb(5'd9, 32'hCAFE_0009);
        tick();
        idle();
        bus.rd_addr1 = 5'd9;
        settle();
        n_vec++; if (bus.rd_data1 !== 32'hCAFE_0009) begin $display("FAIL uf_data: got %h want %h", bus.rd_data1, 32'hCAFE_0009); n_err++; end
        n_vec++; if (bus.wb_underflow !== 1'b1) begin $display("FAIL uf_flag: got %b want 1", bus.wb_underflow); n_err++; end
        n_vec++; if (bus.pending_any !== 1'b0) begin $display("FAIL uf_pending: got %b want 0", bus.pending_any); n_err++; end
        tick();
        tick();
        settle();
        n_vec++; if (bus.wb_underflow !== 1'b1) begin $display("FAIL uf_sticky: got %b want 1", bus.wb_underflow); n_err++; end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        wb(5'd10, 32'h0000_000A);
        tick();
        wb(5'd10, 32'h0000_000B);
        bus.rd_addr1 = 5'd10;
        bus.rd_addr2 = 5'd11;
        settle();
        n_vec++; if (bus.rd_data1 !== 32'h0000_000B) begin $display("FAIL b2b_bypass: got %h want %h", bus.rd_data1, 32'h0000_000B); n_err++; end
        n_vec++; if (bus.rd_data2 !== 32'd0) begin $display("FAIL b2b_other: got %h want %h", bus.rd_data2, 32'd0); n_err++; end
        tick();
        idle();
        issue_dst(5'd12);
        tick();
        issue_dst(5'd12);
        wb(5'd12, 32'h0000_00C1);
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_use1  = 1'b1;
        bus.rd_addr1    = 5'd12;
        settle();
        n_vec++; if (bus.pending_any !== 1'b1) begin $display("FAIL b2b_cancel_pending: got %b want 1", bus.pending_any); n_err++; end
        n_vec++; if (bus.stall !== 1'b1) begin $display("FAIL b2b_cancel_stall: got %b want 1", bus.stall); n_err++; end
        wb(5'd12, 32'h0000_00C2);
        settle();
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL b2b_last_wb: got %b want 0", bus.stall); n_err++; end
        tick();
        idle();
        settle();
        n_vec++; if (bus.pending_any !== 1'b0) begin $display("FAIL b2b_drained: got %b want 0", bus.pending_any); n_err++; end
        tick();
    endtask

    task automatic test_reset_dominates();
        idle();
        issue_dst(5'd4);
        tick();
        issue_dst(5'd4);
        tick();
        idle();
        settle();
        n_vec++; if (bus.pending_any !== 1'b1) begin $display("FAIL rstdom_pending_before: got %b want 1", bus.pending_any); n_err++; end
        rst = 1'b1;
        issue_dst(5'd4);
        wb(5'd5, 32'h0000_0055);
        settle();
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL rstdom_stall: got %b want 0", bus.stall); n_err++; end
        tick();
        rst = 1'b0;
        idle();
        bus.rd_addr1 = 5'd9;
        bus.rd_addr2 = 5'd5;
        settle();
        n_vec++; if (bus.pending_any !== 1'b0) begin $display("FAIL rstdom_pending: got %b want 0", bus.pending_any); n_err++; end
        n_vec++; if (bus.wb_underflow !== 1'b0) begin $display("FAIL rstdom_underflow: got %b want 0", bus.wb_underflow); n_err++; end
        n_vec++; if (bus.rd_data1 !== 32'd0) begin $display("FAIL rstdom_reg9: got %h want %h", bus.rd_data1, 32'd0); n_err++; end
        n_vec++; if (bus.rd_data2 !== 32'd0) begin $display("FAIL rstdom_reg5: got %h want %h", bus.rd_data2, 32'd0); n_err++; end
        bus.issue_valid = 1'b1;
        bus.issue_use1  = 1'b1;
        bus.rd_addr1    = 5'd4;
        settle();
        n_vec++; if (bus.stall !== 1'b0) begin $display("FAIL rstdom_reg4_free: got %b want 0", bus.stall); n_err++; end
        tick();
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        #1;
        test_reset();
        test_raw_hazard();
        test_dst_saturate();
        test_zero_reg();
        test_underflow();
        test_back_to_back();
        test_reset_dominates();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter: WORD, default from definitions.vh (`WORD), register data width.
REQ-002 Parameter: NREG, default 32, number of architectural registers; register NREG-1 (X31) is the zero register.
REQ-003 id_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 id_rst  input  1  reset, synchronous and active-high.
REQ-005 rd_addr1, rd_addr2  input  5 each  decode-stage source register addresses.
REQ-006 rd_data1, rd_data2  output  WORD each  source read data.
REQ-007 issue_valid  input  1  decode presents an instruction this cycle.
REQ-008 issue_use1, issue_use2  input  1 each  instruction consumes source 1 / source 2.
REQ-009 issue_writes  input  1  instruction will write a destination register.
REQ-010 issue_dst  input  5  destination register address.
REQ-011 stall  output  1  instruction not accepted; decode holds it.
REQ-012 wb_reg_write  input  1  write-back stage commits a result (driven by the write-back stage's reg_write_out).
REQ-013 wb_addr  input  5  destination of the committed result.
REQ-014 wb_data  input  WORD  committed result (write-back stage's write_data).
REQ-015 pending_any  output  1  at least one register has an outstanding write.
REQ-016 wb_underflow  output  1  sticky error flag.

Function
REQ-017 Storage: NREG x WORD register array plus one 2-bit pending counter per register (0..3).
REQ-018 Reads combinational; reading X31 returns 0 regardless of array content.
REQ-019 Write-through bypass: if wb_reg_write=1, wb_addr=rd_addrN and wb_addr!=31, rd_dataN=wb_data in the same cycle.
REQ-020 Write: wb_reg_write=1 and wb_addr!=31 -> array[wb_addr]<=wb_data at the edge; writes to X31 are discarded and do not touch any counter.
REQ-021 Source hazard N (N=1,2): issue_useN=1, rd_addrN!=31, and effective count of rd_addrN is nonzero.
REQ-022 Effective count = pending count minus 1 when a same-cycle write-back hits that register, else pending count (bypass resolves the last outstanding write without a stall).
REQ-023 Destination hazard: issue_writes=1, issue_dst!=31, pending count of issue_dst = 3.
REQ-024 stall = issue_valid AND (source hazard 1 OR source hazard 2 OR destination hazard); combinational.
REQ-025 Accept = issue_valid AND NOT stall; accepted with issue_writes=1 and issue_dst!=31 -> count[issue_dst] +1 at the edge.
REQ-026 Committed write-back (REQ-020 conditions) -> count[wb_addr] -1 at the edge.
REQ-027 Same-cycle accept and write-back on the same register: count unchanged.
REQ-028 Write-back to a register with count 0: array still written, count stays 0, wb_underflow set to 1 and held until reset.
REQ-029 Counter never wraps: 3 cannot increment (guaranteed by REQ-023), 0 cannot decrement (REQ-028).
REQ-030 pending_any = OR over all counters being nonzero, registered view (reflects state after the last edge).
REQ-031 Latency: result written at edge k is readable from array from cycle k+1; visible via bypass in cycle k.

Reset
REQ-032 id_rst=1 at an edge: all registers <=0, all counters <=0, wb_underflow<=0; pending_any=0 from the next cycle.
REQ-033 Reset dominates: a write-back or issue coinciding with id_rst is ignored.
REQ-034 stall, rd_data1/2 remain combinational during reset (stall=0 once counters clear, since no hazards).

Verification
REQ-035 Reset, then rd_addr1=5, rd_addr2=31 -> rd_data1=0, rd_data2=0, stall=0, pending_any=0.
REQ-036 Issue dst=3 writes=1; next cycle issue use1=1 rd_addr1=3 with no write-back -> stall=1; then wb_reg_write=1 wb_addr=3 wb_data=0x1234 -> same cycle stall=0, rd_data1=0x1234; next cycle count[3]=0, pending_any=0.
REQ-037 Three accepted issues to dst=7, fourth issue dst=7 -> stall=1; one write-back to 7 in that cycle -> fourth accepted, count stays 3.
REQ-038 Write-back wb_addr=31 wb_data=0xFFFF -> rd_data with addr 31 stays 0, no counter change, wb_underflow=0.
REQ-039 Write-back wb_addr=9 with count[9]=0 -> array[9]=value next cycle, wb_underflow=1 sticky until id_rst.
REQ-040 Issue dst=4 accepted while id_rst=1 with count[4]=2 -> count[4]=0 after edge, pending_any=0.
